// File: rtl/intel_vip_reset_sequencer.sv
// rtl/intel_vip_reset_sequencer.sv - ordered reset release across downstream clock/reset domains
//
// Holds every domain reset asserted until the synchronized PLL lock has been
// stable for LOCK_FILTER cycles, then releases the domains one at a time in
// index order. The next domain is released only after the previous one has
// acknowledged and RELEASE_DELAY gap cycles have passed. A lock loss, a
// software request or an acknowledge timeout reasserts all resets.
//
// Ports:
//   clk_in        sequencer clock
//   reset_in      asynchronous active-high reset
//   pll_locked    PLL lock, asynchronous to clk_in
//   sw_reset_req  one-cycle synchronous request to restart the sequence
//   domain_ack    per-domain "out of reset" indication, asynchronous
//   reset_out     active-high domain resets, registered
//   seq_done      all domains released and acknowledged, registered
//   seq_error     acknowledge timeout occurred, registered
//   state_out     current state encoding (debug)

module intel_vip_reset_sequencer #(
    parameter int NUM_DOMAINS   = 4,
    parameter int SYNC_DEPTH    = 3,
    parameter int HOLD_CYCLES   = 4,
    parameter int LOCK_FILTER   = 8,
    parameter int RELEASE_DELAY = 16,
    parameter int ACK_TIMEOUT   = 64
) (
    input  logic                   clk_in,
    input  logic                   reset_in,
    input  logic                   pll_locked,
    input  logic                   sw_reset_req,
    input  logic [NUM_DOMAINS-1:0] domain_ack,
    output logic [NUM_DOMAINS-1:0] reset_out,
    output logic                   seq_done,
    output logic                   seq_error,
    output logic [2:0]             state_out
);

    localparam int MAX_AB  = (HOLD_CYCLES > LOCK_FILTER) ? HOLD_CYCLES : LOCK_FILTER;
    localparam int MAX_CD  = (RELEASE_DELAY > ACK_TIMEOUT) ? RELEASE_DELAY : ACK_TIMEOUT;
    localparam int MAX_CNT = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
    localparam int CNT_W   = (MAX_CNT > 1) ? $clog2(MAX_CNT) : 1;
    localparam int IDX_W   = (NUM_DOMAINS > 1) ? $clog2(NUM_DOMAINS) : 1;

    typedef enum logic [2:0] {
        ST_ASSERT    = 3'd0,
        ST_WAIT_LOCK = 3'd1,
        ST_RELEASE   = 3'd2,
        ST_WAIT_ACK  = 3'd3,
        ST_GAP       = 3'd4,
        ST_RUNNING   = 3'd5,
        ST_ERROR     = 3'd6
    } state_t;

    state_t                                 state;
    logic [CNT_W-1:0]                       cnt;
    logic [IDX_W-1:0]                       idx;
    logic [SYNC_DEPTH-1:0]                  locked_sync;
    logic [SYNC_DEPTH-1:0][NUM_DOMAINS-1:0] ack_sync;
    logic                                   locked_s;
    logic [NUM_DOMAINS-1:0]                 ack_s;
    logic                                   lock_lost;

    assign locked_s  = locked_sync[SYNC_DEPTH-1];
    assign ack_s     = ack_sync[SYNC_DEPTH-1];
    assign state_out = state;

    // Lock loss only matters once some domain may be (or is about to be)
    // out of reset; ERROR deliberately ignores it.
    assign lock_lost = !locked_s && (state == ST_RELEASE || state == ST_WAIT_ACK ||
                                     state == ST_GAP     || state == ST_RUNNING);

    always_ff @(posedge clk_in or posedge reset_in) begin
        if (reset_in) begin
            locked_sync <= '0;
            ack_sync    <= '0;
        end else begin
            locked_sync <= {locked_sync[SYNC_DEPTH-2:0], pll_locked};
            ack_sync    <= {ack_sync[SYNC_DEPTH-2:0], domain_ack};
        end
    end

    always_ff @(posedge clk_in or posedge reset_in) begin
        if (reset_in) begin
            state     <= ST_ASSERT;
            cnt       <= '0;
            idx       <= '0;
            reset_out <= '1;
            seq_done  <= 1'b0;
            seq_error <= 1'b0;
        end else if (sw_reset_req || lock_lost) begin
            // Entering ASSERT from anywhere, including ASSERT itself, restarts
            // the hold count.
            state     <= ST_ASSERT;
            cnt       <= '0;
            idx       <= '0;
            reset_out <= '1;
            seq_done  <= 1'b0;
            seq_error <= 1'b0;
        end else begin
            case (state)
                ST_ASSERT: begin
                    if (cnt == CNT_W'(HOLD_CYCLES - 1)) begin
                        state <= ST_WAIT_LOCK;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                ST_WAIT_LOCK: begin
                    // Counter tracks consecutive locked cycles.
                    if (!locked_s) begin
                        cnt <= '0;
                    end else if (cnt == CNT_W'(LOCK_FILTER - 1)) begin
                        state <= ST_RELEASE;
                        cnt   <= '0;
                        idx   <= '0;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                ST_RELEASE: begin
                    reset_out[idx] <= 1'b0;
                    state          <= ST_WAIT_ACK;
                    cnt            <= '0;
                end
                ST_WAIT_ACK: begin
                    // Ack is tested first so it wins over a coincident timeout.
                    if (ack_s[idx]) begin
                        cnt <= '0;
                        if (idx == IDX_W'(NUM_DOMAINS - 1)) begin
                            state    <= ST_RUNNING;
                            seq_done <= 1'b1;
                        end else begin
                            state <= ST_GAP;
                        end
                    end else if (cnt == CNT_W'(ACK_TIMEOUT - 1)) begin
                        state     <= ST_ERROR;
                        cnt       <= '0;
                        reset_out <= '1;
                        seq_error <= 1'b1;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                ST_GAP: begin
                    if (cnt == CNT_W'(RELEASE_DELAY - 1)) begin
                        state <= ST_RELEASE;
                        cnt   <= '0;
                        idx   <= idx + IDX_W'(1);
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                ST_RUNNING: begin
                    seq_done  <= 1'b1;
                    reset_out <= '0;
                end
                ST_ERROR: begin
                    seq_error <= 1'b1;
                    reset_out <= '1;
                end
                default: begin
                    state     <= ST_ASSERT;
                    cnt       <= '0;
                    idx       <= '0;
                    reset_out <= '1;
                    seq_done  <= 1'b0;
                    seq_error <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_intel_vip_reset_sequencer.sv
// tb/tb_intel_vip_reset_sequencer.sv - directed self-checking bench for intel_vip_reset_sequencer

module tb_intel_vip_reset_sequencer;

    logic       clk_in;
    logic       reset_in;
    logic       pll_locked;
    logic       sw_reset_req;
    logic [3:0] domain_ack;
    logic [3:0] reset_out;
    logic       seq_done;
    logic       seq_error;
    logic [2:0] state_out;

    int n_checks;
    int n_fail;
    int cyc;
    int ack_cnt [4];
    bit ack_en  [4];

    localparam logic [3:0] EXP_SNAP [4] = '{4'b1110, 4'b1100, 4'b1000, 4'b0000};

    intel_vip_reset_sequencer dut (
        .clk_in       (clk_in),
        .reset_in     (reset_in),
        .pll_locked   (pll_locked),
        .sw_reset_req (sw_reset_req),
        .domain_ack   (domain_ack),
        .reset_out    (reset_out),
        .seq_done     (seq_done),
        .seq_error    (seq_error),
        .state_out    (state_out)
    );

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // One clock: sample 1 time unit after the rising edge, then update the
    // domain model (ack rises 5 cycles after its reset falls, drops with reset).
    task automatic tick();
        @(posedge clk_in);
        #1;
        cyc++;
        for (int i = 0; i < 4; i++) begin
            if (reset_out[i]) begin
                ack_cnt[i]    = 0;
                domain_ack[i] = 1'b0;
            end else begin
                ack_cnt[i]++;
                if (ack_en[i] && ack_cnt[i] >= 5) domain_ack[i] = 1'b1;
            end
        end
    endtask

    task automatic wait_state(input logic [2:0] s, input int budget, output bit found);
        found = 1'b0;
        for (int i = 0; i < budget; i++) begin
            tick();
            if (state_out == s) begin
                found = 1'b1;
                break;
            end
        end
    endtask

    initial begin
        int  fall_cyc [4];
        logic [3:0] snap [4];
        int  done_cyc;
        int  n;
        bit  found;

        n_checks     = 0;
        n_fail       = 0;
        cyc          = 0;
        reset_in     = 1'b1;
        pll_locked   = 1'b1;
        sw_reset_req = 1'b0;
        domain_ack   = 4'b0000;
        for (int i = 0; i < 4; i++) begin
            ack_cnt[i]  = 0;
            ack_en[i]   = 1'b1;
            fall_cyc[i] = -1;
            snap[i]     = 4'b0;
        end

        // Reset state
        repeat (3) tick();
        check("rst_reset_out", reset_out, 4'b1111);
        check("rst_seq_done", seq_done, 0);
        check("rst_seq_error", seq_error, 0);
        check("rst_state", state_out, 0);

        // Nominal sequence
        reset_in = 1'b0;
        cyc      = 0;
        done_cyc = -1;
        for (int k = 0; k < 300 && done_cyc < 0; k++) begin
            tick();
            for (int i = 0; i < 4; i++) begin
                if (fall_cyc[i] < 0 && !reset_out[i]) begin
                    fall_cyc[i] = cyc;
                    snap[i]     = reset_out;
                end
            end
            if (seq_done) done_cyc = cyc;
        end
        check("nom_first_release", fall_cyc[0], 13);
        for (int i = 0; i < 4; i++) check($sformatf("nom_snap%0d", i), snap[i], EXP_SNAP[i]);
        for (int i = 0; i < 3; i++)
            check($sformatf("nom_gap%0d", i), fall_cyc[i+1] - fall_cyc[i], 25);
        check("nom_done_cycle", done_cyc, fall_cyc[3] + 8);
        check("nom_state_running", state_out, 5);
        check("nom_reset_out_zero", reset_out, 4'b0000);

        // Lock loss in RUNNING: takes SYNC_DEPTH+1 edges
        pll_locked = 1'b0;
        repeat (3) tick();
        check("ll_still_running", state_out, 5);
        check("ll_still_released", reset_out, 4'b0000);
        tick();
        check("ll_reset_out", reset_out, 4'b1111);
        check("ll_seq_done", seq_done, 0);
        check("ll_state", state_out, 0);
        pll_locked = 1'b1;
        wait_state(3'd5, 300, found);
        check("ll_rerun_done", found, 1);
        check("ll_rerun_seq_done", seq_done, 1);

        // Lock glitch at filter count 6
        sw_reset_req = 1'b1;
        tick();
        sw_reset_req = 1'b0;
        check("gl_sw_state", state_out, 0);
        check("gl_sw_reset_out", reset_out, 4'b1111);
        repeat (7) tick();
        check("gl_wait_lock", state_out, 1);
        pll_locked = 1'b0;
        repeat (2) tick();
        pll_locked = 1'b1;
        n = 0;
        for (int k = 0; k < 40 && reset_out[0]; k++) begin
            tick();
            n++;
        end
        check("gl_release_delay", n, 12);
        check("gl_release_pattern", reset_out, 4'b1110);

        // sw_reset_req and lock loss together in GAP
        wait_state(3'd4, 60, found);
        check("sl_reach_gap", found, 1);
        sw_reset_req = 1'b1;
        pll_locked   = 1'b0;
        tick();
        sw_reset_req = 1'b0;
        check("sl_state_assert", state_out, 0);
        check("sl_reset_out", reset_out, 4'b1111);
        repeat (3) tick();
        check("sl_hold4", state_out, 0);
        tick();
        check("sl_to_wait_lock", state_out, 1);
        repeat (4) tick();
        check("sl_lock_wait", state_out, 1);
        pll_locked = 1'b1;
        for (int k = 0; k < 40 && reset_out == 4'b1111; k++) tick();
        check("sl_first_idx0", reset_out, 4'b1110);

        // Ack timeout on domain 2
        ack_en[2] = 1'b0;
        for (int k = 0; k < 200 && reset_out != 4'b1000; k++) tick();
        check("to_release2", reset_out, 4'b1000);
        check("to_wait_ack", state_out, 3);
        repeat (63) tick();
        check("to_before_timeout", state_out, 3);
        tick();
        check("to_state_error", state_out, 6);
        check("to_seq_error", seq_error, 1);
        check("to_reset_out", reset_out, 4'b1111);
        check("to_seq_done", seq_done, 0);
        pll_locked = 1'b0;
        repeat (6) tick();
        pll_locked = 1'b1;
        repeat (6) tick();
        check("to_lock_toggle_state", state_out, 6);
        check("to_lock_toggle_err", seq_error, 1);
        sw_reset_req = 1'b1;
        tick();
        sw_reset_req = 1'b0;
        check("to_sw_state", state_out, 0);
        check("to_sw_err_clear", seq_error, 0);

        // Asynchronous reset mid WAIT_ACK
        ack_en[2] = 1'b1;
        wait_state(3'd3, 100, found);
        check("ar_reach_wait_ack", found, 1);
        check("ar_pre_reset_out", reset_out, 4'b1110);
        #3;
        reset_in = 1'b1;
        #1;
        check("ar_reset_out", reset_out, 4'b1111);
        check("ar_seq_done", seq_done, 0);
        check("ar_state", state_out, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
